// File: rtl/chunk_addsub_pkg.sv
// chunk_addsub_pkg -- shared types and default sizes for the chunked adder/subtractor.
package chunk_addsub_pkg;

   // Controller states: waiting, stepping through chunks, presenting the result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CHUNK = 4;

endpackage

// File: rtl/chunk_addsub_add_chunk.sv
// add_chunk -- CHUNK-bit ripple slice: out/co = a + b + ci.
module add_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             ci,
   output logic [CHUNK-1:0] out,
   output logic             co
);

   assign {co, out} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/chunk_addsub.sv
// chunk_addsub -- multi-cycle add/subtract, CHUNK bits per cycle, WIDTH/CHUNK cycles.
// Optional build macro CHUNK_ADDSUB_SAT_EN: saturate sum on signed overflow.
module chunk_addsub
   import chunk_addsub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic             m_clock,
   input  logic             p_reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ov
);

   localparam int N    = WIDTH / CHUNK;
   localparam int IDXW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

   generate
      if (WIDTH % CHUNK != 0) begin : g_bad_width
         $error("chunk_addsub: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
      end
   endgenerate

   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic [IDXW-1:0]  r_idx;
   logic             r_cout;
   logic             r_ov;

   logic             w_accept;
   logic             w_last;
   logic             w_ov;
   logic [CHUNK-1:0] w_chunk_a;
   logic [CHUNK-1:0] w_chunk_b;
   logic [CHUNK-1:0] w_chunk_sum;
   logic             w_chunk_co;

   // A start is honoured only when no chunk computation is in flight.
   assign w_accept  = start && (r_state != RUN);
   assign w_last    = (r_idx == LAST_IDX);
   assign w_chunk_a = r_a[int'(r_idx)*CHUNK +: CHUNK];
   assign w_chunk_b = r_b[int'(r_idx)*CHUNK +: CHUNK];
   // Overflow: like-signed operands giving a result of the other sign (valid on the last chunk).
   assign w_ov      = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_chunk_sum[CHUNK-1] != r_a[WIDTH-1]);

   add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
      .a   (w_chunk_a),
      .b   (w_chunk_b),
      .ci  (r_carry),
      .out (w_chunk_sum),
      .co  (w_chunk_co)
   );

   // State register.
   always_ff @(posedge m_clock) begin
      // NOTE: non-blocking (<=) on every flop so all registers update from pre-edge values.
      if (p_reset) r_state <= IDLE;
      else         r_state <= w_next_state;
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default first, so no path leaves w_next_state unassigned (no latch).
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (start) w_next_state = RUN;
         RUN:     if (w_last) w_next_state = DONE;
         DONE:    w_next_state = start ? RUN : IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Operand capture on an accepted start; b is pre-inverted for subtraction.
   always_ff @(posedge m_clock) begin
      // NOTE: operand registers carry no reset; they are always loaded before use.
      if (w_accept && !p_reset) begin
         r_a <= a;
         r_b <= sub ? ~b : b;
      end
   end

   // Chunk sequencing: carry/index setup on start, one slice per RUN cycle, flags on the last.
   always_ff @(posedge m_clock) begin
      if (p_reset) begin
         r_carry <= 1'b0;
         r_idx   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ov    <= 1'b0;
      end else if (w_accept) begin
         r_carry <= cin;
         r_idx   <= '0;
      end else if (r_state == RUN) begin
         r_sum[int'(r_idx)*CHUNK +: CHUNK] <= w_chunk_sum;
         r_carry <= w_chunk_co;
         r_idx   <= w_last ? '0 : r_idx + 1'b1;
         if (w_last) begin
            r_cout <= w_chunk_co;
            r_ov   <= w_ov;
`ifdef CHUNK_ADDSUB_SAT_EN
            if (w_ov) begin
               r_sum <= r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end
`else
`endif
         end
      end
   end

   assign busy = (r_state == RUN);
   assign done = (r_state == DONE);
   assign sum  = r_sum;
   assign cout = r_cout;
   assign ov   = r_ov;

endmodule

// File: doc/chunk_addsub.md
CHUNK_ADDSUB -- requirements
Module: chunk_addsub

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter: CHUNK, default 4, bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 Port: m_clock  in  1  single clock; all state updates on rising edge.
REQ-004 Port: p_reset  in  1  reset; synchronous, active-high.
REQ-005 Port: start  in  1  request; sampled only when not busy.
REQ-006 Port: sub  in  1  0 = a+b+cin, 1 = a+~b+cin (a-b requires cin=1).
REQ-007 Port: a, b  in  WIDTH  operands; captured on the accepted start.
REQ-008 Port: cin  in  1  carry-in; captured on the accepted start.
REQ-009 Port: busy  out  1  high while chunks are being computed.
REQ-010 Port: done  out  1  one-cycle pulse; result valid.
REQ-011 Port: sum  out  WIDTH  registered result.
REQ-012 Port: cout  out  1  carry out of bit WIDTH-1.
REQ-013 Port: ov  out  1  signed two's-complement overflow.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 Start acceptance: start=1 in IDLE or DONE SHALL latch a, sub?~b:b, and cin into the carry register, clear the chunk index, and go to RUN.
REQ-016 RUN: each cycle SHALL add chunk idx (bits idx*CHUNK+CHUNK-1 : idx*CHUNK) plus the carry register, write sum chunk idx, update carry, and increment idx.
REQ-017 RUN SHALL go to DONE after chunk N-1; DONE SHALL go to IDLE unless start=1.
REQ-018 Latency: with start accepted in cycle 0, busy SHALL be 1 in cycles 1..N and done SHALL be 1 only in cycle N+1.
REQ-019 start while busy=1 SHALL be ignored, with no effect on state or operands.
REQ-020 sum, cout and ov SHALL be defined only from the done cycle and SHALL hold until the next accepted start.
REQ-021 cout SHALL be the final carry; ov = (a[MSB]==b'[MSB]) & (sum[MSB]!=a[MSB]), where b' is the latched, possibly inverted b.
REQ-022 In DONE with start=1, done SHALL still pulse and the new operation SHALL begin (back-to-back, no idle cycle).

Reset
REQ-023 p_reset=1 SHALL force IDLE, busy=0, done=0, sum=0, cout=0, ov=0, idx=0, carry=0.
REQ-024 Reset in RUN or DONE SHALL abort the operation; no done pulse for it SHALL follow.
REQ-025 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-026 With CHUNK_ADDSUB_SAT_EN defined, on ov=1 sum SHALL saturate to 0111..1 if a[MSB]=0 and to 1000..0 if a[MSB]=1; ov SHALL still be 1, and cout SHALL be unchanged.
REQ-027 Without CHUNK_ADDSUB_SAT_EN, sum SHALL wrap modulo 2^WIDTH, and no saturation logic SHALL be present.

Structure
REQ-028 A shared package SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the default WIDTH/CHUNK constants.
REQ-029 The per-cycle adder SHALL be a sub-module, add_chunk (CHUNK-bit a, b, ci -> out, co), instantiated once.
REQ-030 An elaboration-time check SHALL reject WIDTH % CHUNK != 0.

Verification (WIDTH=32, CHUNK=4 unless stated; start in cycle 0)
REQ-031 a=FFFFFFFF, b=00000001, cin=0, sub=0 -> busy in cycles 1..8, done in cycle 9, sum=00000000, cout=1, ov=0.
REQ-032 a=00000005, b=00000007, cin=1, sub=1 -> sum=FFFFFFFE, cout=0, ov=0; a=7, b=5 -> sum=00000002, cout=1.
REQ-033 a=7FFFFFFF, b=00000001, cin=0, sub=0 -> ov=1; sum=80000000 without CHUNK_ADDSUB_SAT_EN, sum=7FFFFFFF with it.
REQ-034 start pulsed in cycle 3 during busy -> ignored, result unchanged; new start in done cycle 9 -> busy in cycles 10..17, done in cycle 18.
REQ-035 p_reset in cycle 4 of an operation -> cycle 5 shows busy=0, sum=0, and no done in cycles 5..20.
REQ-036 WIDTH=8, CHUNK=8: a=80, b=80, cin=0 -> done in cycle 2, sum=00, cout=1, ov=1.
